// File: rtl/contour_fill_if.sv
// Contour-fill handshake bundle: contour in, filled image out.
// Producer/consumer side is master; the fill engine is slave.
interface contour_fill_if #(
  parameter int W = 10,
  parameter int H = 10
);
  localparam int N  = W * H;
  localparam int IW = $clog2(N + 1);

  logic [N-1:0]  contour;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  img;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic [IW-1:0] iter_count;

  modport master (
    output contour, in_valid, out_ready,
    input  in_ready, img, out_valid,
    input  busy, iter_count
  );

  modport slave (
    input  contour, in_valid, out_ready,
    output in_ready, img, out_valid,
    output busy, iter_count
  );
endinterface

// File: rtl/contour_fill.sv
// Fills closed contours by flooding the outside from the border;
// whatever the flood cannot reach (contour + interior) is the image.
module contour_fill #(
  parameter int W = 10,
  parameter int H = 10
) (
  input  logic          clk,
  input  logic          rst,
  contour_fill_if.slave io
);
  localparam int N  = W * H;
  localparam int IW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE, SEED, GROW, DONE
  } state_t;

  function automatic logic [N-1:0] col_mask(
    input int c
  );
    logic [N-1:0] m;
    m = '0;
    for (int r = 0; r < H; r++) m[r*W+c] = 1'b1;
    return m;
  endfunction

  function automatic logic [N-1:0] row_mask(
    input int r
  );
    logic [N-1:0] m;
    m = '0;
    for (int c = 0; c < W; c++) m[r*W+c] = 1'b1;
    return m;
  endfunction

  localparam logic [N-1:0] COL0 = col_mask(0);
  localparam logic [N-1:0] COLL = col_mask(W - 1);
  localparam logic [N-1:0] BORDER =
    row_mask(0) | row_mask(H - 1) | COL0 | COLL;

  state_t        st, st_nxt;
  logic [N-1:0]  c_q, o_q, img_q;
  logic [N-1:0]  nbr, o_nxt;
  logic [IW-1:0] iter_q;
  logic          cap, seed, grow, fin, last;

  // column masks stop horizontal shifts wrapping between rows
  always_comb begin
    nbr = ((o_q << 1) & ~COL0)
        | ((o_q >> 1) & ~COLL)
        | (o_q << W)
        | (o_q >> W);
    o_nxt = o_q | (nbr & ~c_q);
    last  = (o_nxt == o_q)
         || (iter_q == IW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    cap    = 1'b0;
    seed   = 1'b0;
    grow   = 1'b0;
    fin    = 1'b0;
    unique case (1'b1)
      (st == IDLE): begin
        if (io.in_valid) begin
          cap    = 1'b1;
          st_nxt = SEED;
        end
      end
      (st == SEED): begin
        seed   = 1'b1;
        st_nxt = GROW;
      end
      (st == GROW): begin
        grow = 1'b1;
        if (last) begin
          fin    = 1'b1;
          st_nxt = DONE;
        end
      end
      (st == DONE): begin
        if (io.out_ready) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q    <= '0;
      o_q    <= '0;
      img_q  <= '0;
      iter_q <= '0;
    end else begin
      if (cap) begin
        c_q    <= io.contour;
        iter_q <= '0;
      end
      if (seed) o_q <= BORDER & ~c_q;
      if (grow) begin
        o_q    <= o_nxt;
        iter_q <= iter_q + IW'(1);
      end
      if (fin) img_q <= ~o_nxt;
    end
  end

  assign io.in_ready   = (st == IDLE);
  assign io.out_valid  = (st == DONE);
  assign io.busy       = (st != IDLE);
  assign io.img        = img_q;
  assign io.iter_count = iter_q;
endmodule

// File: doc/contour_fill.md
CONTOUR_FILL -- requirements
Module: contour_fill

Interface
REQ-001: Parameter W, default 10, image width in pixels.
REQ-002: Parameter H, default 10, image height in pixels.
REQ-003: clk  input  1  sole clock; all state updates on rising edge.
REQ-004: rst  input  1  reset, asynchronous and active-high.
REQ-005: contour  input  W*H  contour bitmap; bit i = row i/W, column i%W; 1 = object boundary pixel.
REQ-006: in_valid  input  1  contour word valid.
REQ-007: in_ready  output  1  block can accept a contour.
REQ-008: img  output  W*H  reconstructed filled binary image, same bit mapping as contour.
REQ-009: out_valid  output  1  img valid.
REQ-010: out_ready  input  1  downstream accepts img.
REQ-011: busy  output  1  high in any state other than IDLE.
REQ-012: iter_count  output  clog2(W*H+1)  number of GROW cycles used for the current or last frame.

Function
REQ-013: The FSM SHALL have states IDLE, SEED, GROW and DONE, with in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-014: IDLE: on in_valid&in_ready, latch contour into internal register C, clear iter_count, and go to SEED; otherwise stay.
REQ-015: SEED (1 cycle): outside register O = border mask & ~C, where the border is row 0, row H-1, column 0 and column W-1; go to GROW.
REQ-016: GROW (1 dilation per cycle): O_next = O | (N4(O) & ~C); iter_count += 1.
REQ-017: N4 SHALL be 4-connected (left/right/up/down) with no wrap-around; out-of-grid neighbours count as 0.
REQ-018: GROW SHALL go to DONE when O_next == O, or when iter_count reaches W*H (safety bound); otherwise it stays in GROW.
REQ-019: On entry to DONE, img SHALL be registered as ~O (contour pixels plus enclosed interior).
REQ-020: DONE: hold img, out_valid and iter_count stable until out_valid&out_ready, then go to IDLE in the next cycle.
REQ-021: Latency from the input handshake edge to out_valid high SHALL be 2 + k cycles, where k = the number of GROW cycles (k >= 1).
REQ-022: in_valid while not in IDLE SHALL be ignored, with no capture and no state change.
REQ-023: The contour input SHALL be sampled only at the handshake; later changes SHALL have no effect on the current frame.
REQ-024: img SHALL retain the last completed frame after the output handshake until the next DONE entry.
REQ-025: A single frame SHALL be in flight at a time; there is no input buffering.

Reset
REQ-026: While rst is high, state=IDLE, C=0, O=0, img=0, iter_count=0, out_valid=0, busy=0 and in_ready=1, applied immediately.
REQ-027: Reset asserted in any state, including mid-GROW and DONE, SHALL abort the frame with no output handshake.
REQ-028: The first handshake SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-029: Contour all-zero (W=H=10) -> out_valid after 7 cycles, iter_count=5, img=0.
REQ-030: Contour = perimeter of square rows 2-7, cols 2-7 (20 bits) -> img = 36-pixel solid block rows 2-7, cols 2-7, all other bits 0.
REQ-031: Contour all-ones -> iter_count=1, out_valid after 3 cycles, img all ones.
REQ-032: Contour = full-grid perimeter (rows 0 and 9, cols 0 and 9) -> O empty after SEED, img all ones, iter_count=1.
REQ-033: Backpressure: out_ready low for 3 cycles in DONE, with in_valid held high -> img and out_valid stable, in_ready=0, no second capture; accept on the cycle out_ready rises, then in_ready=1 one cycle later.
REQ-034: rst pulsed during the 3rd GROW cycle -> all outputs take reset values immediately; the next frame completes normally with correct img.
